// File: rtl/paicore_dp_pkg.sv
// ----------------------------------------------------------------------------
// paicore_dp_pkg
//   Shared constants and types for the PAICore downstream datapath.
//   DATA_W        : frame width on both the AXIS and the PAICore send side
//   CNT_W         : width of the delivered-frame counter
//   TAIL_PATTERN  : marker value carried on a stripped tlast beat
//   BUF_DEPTH     : number of entries in the skid buffer
//   tx_state_t    : transfer control FSM states
// ----------------------------------------------------------------------------
package paicore_dp_pkg;

    localparam int DATA_W = 64;
    localparam int CNT_W  = 32;
    localparam logic [DATA_W-1:0] TAIL_PATTERN = {DATA_W{1'b1}};
    localparam int BUF_DEPTH = 2;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RUN   = 3'd1,
        FLUSH = 3'd2,
        DONE  = 3'd3,
        WAIT  = 3'd4
    } tx_state_t;

endpackage

// File: rtl/transport_skid_buf.sv
// ----------------------------------------------------------------------------
// transport_skid_buf
//   Two-entry in-order FIFO used as a skid buffer between the AXIS input and
//   the PAICore send port. The upstream ready is registered: it is computed
//   from the occupancy the buffer will have after this cycle's push/pop, so
//   a beat accepted while ready is high always has a free slot.
//
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   synchronous active-low reset
//   push       in   write din this cycle (ignored when full)
//   din        in   W-bit data to store
//   pop        in   head consumed this cycle (ignored when empty)
//   flush      in   discard all entries (wins over push/pop)
//   allow      in   upstream may be offered a ready next cycle
//   ready      out  registered upstream ready
//   valid      out  buffer non-empty (head valid)
//   dout       out  head entry
//   empty_next out  buffer will be empty after this cycle
// ----------------------------------------------------------------------------
module transport_skid_buf #(
    parameter int W = paicore_dp_pkg::DATA_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    input  logic         flush,
    input  logic         allow,
    output logic         ready,
    output logic         valid,
    output logic [W-1:0] dout,
    output logic         empty_next
);
    import paicore_dp_pkg::*;

    localparam logic [1:0] FULL = 2'(BUF_DEPTH);

    logic [W-1:0] head;
    logic [W-1:0] tail;
    logic [1:0]   count_q;
    logic [1:0]   count_d;
    logic         do_push;
    logic         do_pop;

    // A pop only counts when something is stored; a push is refused when
    // full. With the registered ready a full push cannot be offered, but the
    // guard keeps the storage safe regardless of the caller.
    assign do_pop  = pop && (count_q != 2'd0);
    assign do_push = push && (count_q != FULL);

    // Occupancy after this cycle's activity; drives the registered ready.
    always_comb begin
        count_d = count_q;
        if (flush) begin
            count_d = 2'd0;
        end else begin
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + 2'd1;
                2'b01:   count_d = count_q - 2'd1;
                default: count_d = count_q;
            endcase
        end
    end

    // Storage: head is always the oldest entry. On a pop with two entries
    // the tail shifts into the head; an incoming beat fills whichever slot
    // becomes the youngest.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            head    <= '0;
            tail    <= '0;
            count_q <= 2'd0;
            ready   <= 1'b0;
        end else if (flush) begin
            head    <= '0;
            tail    <= '0;
            count_q <= 2'd0;
            ready   <= allow;
        end else begin
            count_q <= count_d;
            ready   <= allow && (count_d != FULL);
            if (do_pop) begin
                if (count_q == FULL) begin
                    head <= tail;
                    if (do_push) begin
                        tail <= din;
                    end
                end else if (do_push) begin
                    head <= din;
                end
            end else if (do_push) begin
                if (count_q == 2'd0) begin
                    head <= din;
                end else begin
                    tail <= din;
                end
            end
        end
    end

    assign valid      = (count_q != 2'd0);
    assign dout       = head;
    assign empty_next = (count_d == 2'd0);

endmodule

// File: rtl/transport_down.sv
// ----------------------------------------------------------------------------
// transport_down
//   Downstream transport stage: drains frames from the AXI-Stream DMA/FIFO
//   and hands them to the PAICore send port over valid/ready. Frames are
//   counted, a single done pulse marks the end of a transfer, and an
//   all-ones tail marker on the tlast beat can be stripped.
//
// Ports
//   s_axis_aclk     in   clock, all logic rising-edge
//   s_axis_aresetn  in   synchronous active-low reset
//   s_axis_tvalid   in   AXIS beat valid
//   s_axis_tready   out  AXIS ready (registered)
//   s_axis_tdata    in   AXIS data
//   s_axis_tlast    in   last beat of the transfer
//   s_axis_hsked    out  AXIS handshake this cycle
//   o_send_valid    out  frame valid to PAICore
//   i_send_ready    in   PAICore accepts the frame this cycle
//   o_send_tdata    out  frame to PAICore
//   i_tx_sending    in   transfer enable; low = idle / abort
//   o_tx_done       out  one-cycle transfer-complete pulse
//   o_frame_count   out  frames delivered in the current transfer
// ----------------------------------------------------------------------------
module transport_down #(
    parameter int                DATA_W       = paicore_dp_pkg::DATA_W,
    parameter int                CNT_W        = paicore_dp_pkg::CNT_W,
    parameter logic [DATA_W-1:0] TAIL_PATTERN = paicore_dp_pkg::TAIL_PATTERN,
    parameter bit                DROP_TAIL    = 1'b1
) (
    input  logic              s_axis_aclk,
    input  logic              s_axis_aresetn,
    input  logic              s_axis_tvalid,
    output logic              s_axis_tready,
    input  logic [DATA_W-1:0] s_axis_tdata,
    input  logic              s_axis_tlast,
    output logic              s_axis_hsked,
    output logic              o_send_valid,
    input  logic              i_send_ready,
    output logic [DATA_W-1:0] o_send_tdata,
    input  logic              i_tx_sending,
    output logic              o_tx_done,
    output logic [CNT_W-1:0]  o_frame_count
);
    import paicore_dp_pkg::*;

    tx_state_t state;
    tx_state_t state_next;

    logic hsk;
    logic tail_beat;
    logic active;
    logic abort;
    logic push;
    logic pop;
    logic allow;
    logic empty_next;

    assign hsk          = s_axis_tvalid && s_axis_tready;
    assign s_axis_hsked = hsk;

    // A tlast beat carrying the marker is handshaked on AXIS but never
    // reaches PAICore.
    assign tail_beat = DROP_TAIL && s_axis_tlast && (s_axis_tdata == TAIL_PATTERN);

    // Dropping the enable while data is moving abandons the transfer; this
    // also beats a tlast arriving in the same cycle.
    assign active = (state == RUN) || (state == FLUSH);
    assign abort  = active && !i_tx_sending;

    assign push  = hsk && (state == RUN) && i_tx_sending && !tail_beat;
    assign pop   = o_send_valid && i_send_ready;
    assign allow = (state_next == RUN);

    transport_skid_buf #(
        .W (DATA_W)
    ) u_skid (
        .clk        (s_axis_aclk),
        .rst_n      (s_axis_aresetn),
        .push       (push),
        .din        (s_axis_tdata),
        .pop        (pop),
        .flush      (abort),
        .allow      (allow),
        .ready      (s_axis_tready),
        .valid      (o_send_valid),
        .dout       (o_send_tdata),
        .empty_next (empty_next)
    );

    // State register.
    always_ff @(posedge s_axis_aclk) begin
        if (!s_axis_aresetn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic. FLUSH leaves as soon as the buffer will be empty
    // after this cycle, so the done pulse lands in the cycle right after
    // PAICore takes the final frame. WAIT holds until the enable drops so a
    // long-held enable cannot trigger a second pulse.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (i_tx_sending) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (!i_tx_sending) begin
                    state_next = IDLE;
                end else if (hsk && s_axis_tlast) begin
                    state_next = FLUSH;
                end
            end
            FLUSH: begin
                if (!i_tx_sending) begin
                    state_next = IDLE;
                end else if (empty_next) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = WAIT;
            end
            WAIT: begin
                if (!i_tx_sending) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign o_tx_done = (state == DONE);

    // Delivered-frame counter: cleared on entry to a new transfer, held
    // across an abort, saturating rather than wrapping.
    always_ff @(posedge s_axis_aclk) begin
        if (!s_axis_aresetn) begin
            o_frame_count <= '0;
        end else if ((state == IDLE) && i_tx_sending) begin
            o_frame_count <= '0;
        end else if (pop && (o_frame_count != {CNT_W{1'b1}})) begin
            o_frame_count <= o_frame_count + 1'b1;
        end
    end

endmodule
